memory_cycle: RTL and testbench

- Memory stage of the 5-stage RISC-V pipeline.
- Consumes the registered E->M bundle produced by the execute stage and performs word loads/stores over a request/response data-memory bus.
- Stalls the pipeline while a memory access is outstanding, then registers the M->W bundle for writeback.
- Exports M-stage fields to the hazard unit for forwarding.

---
 rtl/memory_cycle_pkg.sv | 16 +
 rtl/memory_cycle_if.sv | 11 +
 rtl/memory_cycle_mw_pipe_reg.sv | 17 +
 rtl/memory_cycle.sv | 81 ++++++++
 tb/tb_memory_cycle.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_cycle_pkg.sv
// riscv_pipe_pkg: shared encodings, FSM state and M->W bundle for the memory stage.
package riscv_pipe_pkg;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic        mem_err;
  } mw_t;
endpackage

// File: rtl/memory_cycle_if.sv
// memory_cycle_if: request/response data-memory bus between the memory stage and dmem.
interface memory_cycle_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ready, dmem_rdata);
  modport slave (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ready, dmem_rdata);
endinterface

// File: rtl/memory_cycle_mw_pipe_reg.sv
// mw_pipe_reg: M->W register; a bubble kills write-back and error, other fields hold.
module mw_pipe_reg
  import riscv_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bubble,
  input  mw_t  d,
  output mw_t  q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (bubble) begin
      q.reg_write <= 1'b0;
      q.mem_err   <= 1'b0;
    end else q <= d;
endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: RISC-V memory stage; word load/store over dmem with stall, timeout and M->W register.
module memory_cycle
  import riscv_pipe_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [4:0]           RD_M,
  input  logic [31:0]          ALUResultM,
  input  logic [31:0]          WriteDataM,
  input  logic [31:0]          PCPlus4M,
  memory_cycle_if.master       dmem,
  output logic                 StallM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [4:0]           RD_W,
  output logic [31:0]          ALUResultW,
  output logic [31:0]          ReadDataW,
  output logic [31:0]          PCPlus4W,
  output logic                 MemErrW,
  output logic [31:0]          ALUResultM_H,
  output logic [4:0]           RD_M_H,
  output logic                 RegWriteM_H
);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             memop, mis, go, at_max, timeout, err, load;
  mw_t              w_d, w_q;
  assign memop   = MemWriteM | (ResultSrcM == RES_MEM);
  assign mis     = memop & |ALUResultM[1:0];
  assign go      = memop & !mis;
  assign load    = (ResultSrcM == RES_MEM) & !MemWriteM;
  assign at_max  = cnt == CNT_W'(MAX_WAIT);
  assign timeout = (state == WAIT) & !dmem.dmem_ready & at_max;
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = (state == IDLE) ? ((go & !dmem.dmem_ready) ? WAIT : IDLE)
                              : ((dmem.dmem_ready | at_max) ? IDLE : WAIT);
    cnt_n   = (state == IDLE) ? ((go & !dmem.dmem_ready) ? CNT_W'(1) : '0)
                              : ((dmem.dmem_ready | at_max) ? '0 : cnt + CNT_W'(1));
  end
  // The bus fields track the M inputs directly; upstream holds them while stalled.
  always_comb begin
    dmem.dmem_req   = rst & (state == IDLE) & go;
    dmem.dmem_we    = MemWriteM;
    dmem.dmem_addr  = ALUResultM;
    dmem.dmem_wdata = WriteDataM;
    StallM = rst & !dmem.dmem_ready & (((state == IDLE) & go) | ((state == WAIT) & !at_max));
    err    = ((state == IDLE) & mis) | timeout;
    w_d.reg_write  = RegWriteM & !err;
    w_d.result_src = ResultSrcM;
    w_d.rd         = RD_M;
    w_d.alu_result = ALUResultM;
    w_d.read_data  = (load & go & dmem.dmem_ready) ? dmem.dmem_rdata : '0;
    w_d.pc_plus4   = PCPlus4M;
    w_d.mem_err    = err;
  end
  mw_pipe_reg u_mw (.clk(clk), .rst(rst), .bubble(StallM), .d(w_d), .q(w_q));
  assign RegWriteW    = w_q.reg_write;
  assign ResultSrcW   = w_q.result_src;
  assign RD_W         = w_q.rd;
  assign ALUResultW   = w_q.alu_result;
  assign ReadDataW    = w_q.read_data;
  assign PCPlus4W     = w_q.pc_plus4;
  assign MemErrW      = w_q.mem_err;
  assign ALUResultM_H = ALUResultM;
  assign RD_M_H       = RD_M;
  assign RegWriteM_H  = RegWriteM;
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: scoreboard bench for memory_cycle with MAX_WAIT=4.
module tb_memory_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        rw_m, mw_m;
  logic [1:0]  rs_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_m, wd_m, pc4_m;
  logic        stall;
  logic        rw_w, err_w;
  logic [1:0]  rs_w;
  logic [4:0]  rd_w, rd_h;
  logic [31:0] alu_w, rdata_w, pc4_w, alu_h;
  logic        rw_h;
  logic [104:0] w_obs, exp_w, last;
  logic [104:0] sb[$];
  int checks = 0;
  int failures = 0;
  memory_cycle_if bus();
  memory_cycle #(.MAX_WAIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .RegWriteM(rw_m), .MemWriteM(mw_m), .ResultSrcM(rs_m), .RD_M(rd_m),
    .ALUResultM(alu_m), .WriteDataM(wd_m), .PCPlus4M(pc4_m), .dmem(bus), .StallM(stall),
    .RegWriteW(rw_w), .ResultSrcW(rs_w), .RD_W(rd_w), .ALUResultW(alu_w), .ReadDataW(rdata_w),
    .PCPlus4W(pc4_w), .MemErrW(err_w), .ALUResultM_H(alu_h), .RD_M_H(rd_h), .RegWriteM_H(rw_h)
  );
  assign w_obs = {rw_w, rs_w, rd_w, alu_w, rdata_w, pc4_w, err_w};
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [104:0] mk(input logic rw, input logic [1:0] rs, input logic [4:0] rd,
                                      input logic [31:0] alu, input logic [31:0] rdata,
                                      input logic [31:0] pc4, input logic err);
    return {rw, rs, rd, alu, rdata, pc4, err};
  endfunction
  function automatic logic [104:0] bubble_of(input logic [104:0] w);
    return {1'b0, w[103:1], 1'b0};
  endfunction
  task automatic drive(input logic rw, input logic mw, input logic [1:0] rs, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                       input logic rdy, input logic [31:0] rdata);
    rw_m = rw; mw_m = mw; rs_m = rs; rd_m = rd; alu_m = alu; wd_m = wd; pc4_m = pc4;
    bus.dmem_ready = rdy; bus.dmem_rdata = rdata;
  endtask
  task automatic push(input logic [104:0] e);
    sb.push_back(e);
    last = e;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 2)), 5'($urandom),
            $urandom, $urandom, $urandom, $urandom_range(0, 1), $urandom);
      #1;
      checks++;
      if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_comb req=%b stall=%b exp 0 0", bus.dmem_req, stall);
      end
      @(posedge clk); #1;
      checks++;
      if (w_obs !== '0) begin
        failures++;
        $display("FAIL reset_w got=%h exp=0", w_obs);
      end
    end
    last = '0;
    rst = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_alu;
    drive(1, 0, 2'b00, 5, 32'h1234, 32'h9, 32'h44, 0, 0);
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || stall !== 1'b0 || alu_h !== 32'h1234 || rd_h !== 5'd5 || rw_h !== 1'b1) begin
      failures++;
      $display("FAIL alu_comb req=%b stall=%b alu_h=%h rd_h=%0d rw_h=%b exp 0 0 1234 5 1",
               bus.dmem_req, stall, alu_h, rd_h, rw_h);
    end
    push(mk(1, 2'b00, 5, 32'h1234, 0, 32'h44, 0));
    @(posedge clk); #1;
    exp_w = sb.pop_front();
    checks++;
    if (w_obs !== exp_w) begin
      failures++;
      $display("FAIL alu_w got=%h exp=%h", w_obs, exp_w);
    end
  endtask
  task automatic test_zero_wait_load;
    drive(1, 0, 2'b01, 7, 32'h100, 0, 32'h48, 1, 32'hDEADBEEF);
    #1;
    checks++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h100 || stall !== 1'b0) begin
      failures++;
      $display("FAIL zw_load_comb req=%b we=%b addr=%h stall=%b exp 1 0 100 0",
               bus.dmem_req, bus.dmem_we, bus.dmem_addr, stall);
    end
    push(mk(1, 2'b01, 7, 32'h100, 32'hDEADBEEF, 32'h48, 0));
    @(posedge clk); #1;
    exp_w = sb.pop_front();
    checks++;
    if (w_obs !== exp_w) begin
      failures++;
      $display("FAIL zw_load_w got=%h exp=%h", w_obs, exp_w);
    end
  endtask
  task automatic test_store_wait;
    int stalls = 0;
    int reqs = 0;
    drive(0, 1, 2'b00, 0, 32'h200, 32'hCAFEF00D, 32'h4C, 0, 32'h77);
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ready = (i == 3);
      #1;
      stalls += int'(stall);
      reqs += int'(bus.dmem_req);
      checks++;
      if (stall !== (i < 3) || bus.dmem_req !== (i == 0) || bus.dmem_we !== 1'b1 || bus.dmem_wdata !== 32'hCAFEF00D) begin
        failures++;
        $display("FAIL store_comb cyc=%0d stall=%b req=%b we=%b wdata=%h exp %b %b 1 cafef00d",
                 i, stall, bus.dmem_req, bus.dmem_we, bus.dmem_wdata, i < 3, i == 0);
      end
      push((i < 3) ? bubble_of(last) : mk(0, 2'b00, 0, 32'h200, 0, 32'h4C, 0));
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (w_obs !== exp_w) begin
        failures++;
        $display("FAIL store_w cyc=%0d got=%h exp=%h", i, w_obs, exp_w);
      end
    end
    checks++;
    if (stalls != 3 || reqs != 1) begin
      failures++;
      $display("FAIL store_counts stalls=%0d reqs=%0d exp 3 1", stalls, reqs);
    end
  endtask
  task automatic test_misaligned;
    drive(1, 0, 2'b01, 9, 32'h102, 0, 32'h50, 1, 32'h11111111);
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL mis_comb req=%b stall=%b exp 0 0", bus.dmem_req, stall);
    end
    push(mk(0, 2'b01, 9, 32'h102, 0, 32'h50, 1));
    @(posedge clk); #1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    push(mk(0, 2'b00, 0, 0, 0, 0, 0));
    exp_w = sb.pop_front();
    checks++;
    if (w_obs !== exp_w) begin
      failures++;
      $display("FAIL mis_w got=%h exp=%h", w_obs, exp_w);
    end
    @(posedge clk); #1;
    exp_w = sb.pop_front();
    checks++;
    if (w_obs !== exp_w) begin
      failures++;
      $display("FAIL mis_err_clear got=%h exp=%h", w_obs, exp_w);
    end
  endtask
  task automatic test_timeout;
    drive(1, 0, 2'b01, 3, 32'h300, 0, 32'h54, 0, 32'h99);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (stall !== (i < 4)) begin
        failures++;
        $display("FAIL timeout_stall cyc=%0d got=%b exp=%b", i, stall, i < 4);
      end
      push((i < 4) ? bubble_of(last) : mk(0, 2'b01, 3, 32'h300, 0, 32'h54, 1));
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (w_obs !== exp_w) begin
        failures++;
        $display("FAIL timeout_w cyc=%0d got=%h exp=%h", i, w_obs, exp_w);
      end
    end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    push(mk(0, 2'b00, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    exp_w = sb.pop_front();
    checks++;
    if (w_obs !== exp_w) begin
      failures++;
      $display("FAIL timeout_err_clear got=%h exp=%h", w_obs, exp_w);
    end
  endtask
  task automatic test_reset_in_wait;
    drive(1, 0, 2'b01, 4, 32'h400, 0, 32'h58, 0, 0);
    for (int i = 0; i < 2; i++) begin
      push(bubble_of(last));
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (w_obs !== exp_w || stall !== 1'b1) begin
        failures++;
        $display("FAIL rstwait_pre cyc=%0d got=%h stall=%b exp=%h 1", i, w_obs, stall, exp_w);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstwait_comb stall=%b req=%b exp 0 0", stall, bus.dmem_req);
    end
    push('0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h5555);
    exp_w = sb.pop_front();
    last = '0;
    checks++;
    if (w_obs !== exp_w) begin
      failures++;
      $display("FAIL rstwait_w got=%h exp=%h", w_obs, exp_w);
    end
    #1;
    checks++;
    if (stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL late_ready_comb stall=%b req=%b exp 0 0", stall, bus.dmem_req);
    end
    push('0);
    @(posedge clk); #1;
    exp_w = sb.pop_front();
    checks++;
    if (w_obs !== exp_w) begin
      failures++;
      $display("FAIL late_ready_w got=%h exp=%h", w_obs, exp_w);
    end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2'b01, 5'(10 + i), 32'h500 + 32'(4 * i), 0, 32'h60 + 32'(4 * i), 1, 32'hA000_0000 + 32'(i));
      #1;
      checks++;
      if (bus.dmem_req !== 1'b1 || stall !== 1'b0 || bus.dmem_addr !== 32'h500 + 32'(4 * i)) begin
        failures++;
        $display("FAIL b2b_comb cyc=%0d req=%b stall=%b addr=%h", i, bus.dmem_req, stall, bus.dmem_addr);
      end
      push(mk(1, 2'b01, 5'(10 + i), 32'h500 + 32'(4 * i), 32'hA000_0000 + 32'(i), 32'h60 + 32'(4 * i), 0));
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (w_obs !== exp_w) begin
        failures++;
        $display("FAIL b2b_w cyc=%0d got=%h exp=%h", i, w_obs, exp_w);
      end
    end
  endtask
  initial begin
    test_reset;
    test_alu;
    test_zero_wait_load;
    test_store_wait;
    test_misaligned;
    test_timeout;
    test_reset_in_wait;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
